// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory path.
// Holds the responder FSM state encoding and the byte-merge helper.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    function automatic logic [WORD_W-1:0] be_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [3:0]        be
    );
        logic [WORD_W-1:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core datapath and the data memory.
// master = core side, slave = memory responder.
interface dmem_responder_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised data storage: byte-enabled synchronous write,
// combinational read. Contents are never reset.
module dmem_array
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    assign rdata = mem[addr];

    // Merge the enabled bytes of wdata into the addressed word.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= be_merge(mem[addr], wdata, be);
    end
endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for core loads/stores with LATENCY wait cycles.
// Optional: DMEM_ALIGN_CHECK_EN flags non-word-aligned addresses as errors.
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);
    localparam bit ZERO_LAT = (LATENCY == 0);

    dmem_state_t       state;
    logic [3:0]        cnt;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [WORD_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              we_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic              err_q;

    logic              accept;
    logic              wait_done;
    logic              go_resp;
    logic [ADDR_W-1:0] addr;
    logic              range_err;
    logic              req_err;
    logic              cur_we;
    logic [AW-1:0]     cur_idx;
    logic [WORD_W-1:0] cur_wdata;
    logic [3:0]        cur_be;
    logic              cur_err;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    assign addr      = bus.req_addr;
    assign range_err = |addr[ADDR_W-1:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_err = range_err | (|addr[1:0]);
`else
    logic unused_lsb;
    assign unused_lsb = ^addr[1:0];
    assign req_err = range_err;
`endif

    assign accept    = (state == IDLE) && req_ready_q && bus.req_valid;
    assign wait_done = (state == WAIT) && (cnt == LAT - 4'd1);
    assign go_resp   = (accept && ZERO_LAT) || wait_done;

    // With zero latency the response is built from the live request.
    always_comb begin
        cur_we    = we_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        cur_err   = err_q;
        if (state == IDLE) begin
            cur_we    = bus.req_we;
            cur_idx   = addr[AW+1:2];
            cur_wdata = bus.req_wdata;
            cur_be    = bus.req_be;
            cur_err   = req_err;
        end
    end

    assign mem_we = rst && go_resp && cur_we && !cur_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (cur_be),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // Transaction FSM: capture, wait out the latency, hold the response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        we_q        <= bus.req_we;
                        idx_q       <= addr[AW+1:2];
                        wdata_q     <= bus.req_wdata;
                        be_q        <= bus.req_be;
                        err_q       <= req_err;
                        cnt         <= 4'd0;
                        req_ready_q <= 1'b0;
                        state       <= ZERO_LAT ? RESP : WAIT;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_done) state <= RESP;
                    else           cnt   <= cnt + 4'd1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= cur_err;
                rsp_rdata_q <= (cur_we || cur_err) ? '0 : mem_rdata;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder.
// Reference model: flat word array updated with byte masks.
module tb_dmem_responder;
    import mips_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst;

    dmem_responder_if #(.ADDR_W(32)) bus ();

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .ADDR_W      (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] mm [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic run(input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int hold, input bit poke,
                       output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] idx, mask, exp_rd;
        logic exp_err;
        idx = a >> 2;
        exp_err = (idx >= DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) exp_err = 1'b1;
`endif
        exp_rd = (we || exp_err) ? 32'h0 : mm[idx[7:0]];
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_be    = be;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        n = 1;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        chk("latency", 32'(n), 32'(LAT + 1));
        chk("rdata", bus.rsp_rdata, exp_rd);
        chk("err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_addr  = a & 32'h3FC;
                bus.req_wdata = 32'hFFFF_FFFF;
                bus.req_be    = BE_WORD;
            end
            @(negedge clk);
            chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("hold_rdata", bus.rsp_rdata, exp_rd);
            chk("hold_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
            chk("hold_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("post_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("post_rdata", bus.rsp_rdata, 32'h0);
        chk("post_err", {31'b0, bus.rsp_err}, 32'd0);
        chk("post_ready", {31'b0, bus.req_ready}, 32'd1);
        if (we && !exp_err) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            mm[idx[7:0]] = (mm[idx[7:0]] & ~mask) | (wd & mask);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        logic [31:0] a;
        int n;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;

        // reset state
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
            chk("rst_err", {31'b0, bus.rsp_err}, 32'd0);
            chk("rst_rdata", bus.rsp_rdata, 32'h0);
            chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_up", {31'b0, bus.req_ready}, 32'd1);

        // initialise the words the bench uses
        for (int w = 0; w < 16; w++)
            run(1'b1, 32'(w * 4), $urandom, BE_WORD, 0, 1'b0, rd, er);

        // full store then load
        run(1'b1, 32'h10, 32'hDEAD_BEEF, BE_WORD, 0, 1'b0, rd, er);
        run(1'b0, 32'h10, 32'h0, BE_WORD, 0, 1'b0, rd, er);
        chk("t2_load", rd, 32'hDEAD_BEEF);

        // partial byte store
        run(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 1'b0, rd, er);
        run(1'b0, 32'h10, 32'h0, 4'b0000, 0, 1'b0, rd, er);
        chk("t3_load", rd, 32'hDEAD_BEAA);

        // no-op store
        run(1'b1, 32'h10, 32'h1111_1111, 4'b0000, 0, 1'b0, rd, er);
        chk("noop_err", {31'b0, er}, 32'd0);

        // out of range
        run(1'b0, 32'h400, 32'h0, BE_WORD, 0, 1'b0, rd, er);
        chk("t4_err", {31'b0, er}, 32'd1);
        chk("t4_rdata", rd, 32'h0);
        run(1'b1, 32'hFFFF_FFFC, 32'h5555_5555, BE_WORD, 0, 1'b0, rd, er);
        run(1'b0, 32'h0, 32'h0, BE_WORD, 0, 1'b0, rd, er);
        chk("t4_word0", rd, mm[0]);

        // stall in RESP while a new request is offered
        run(1'b0, 32'h10, 32'h0, BE_WORD, 5, 1'b1, rd, er);
        run(1'b0, 32'h10, 32'h0, BE_WORD, 0, 1'b0, rd, er);
        chk("t5_load", rd, 32'hDEAD_BEAA);

        // reset during WAIT drops the store
        run(1'b1, 32'h20, 32'h0BAD_F00D, BE_WORD, 0, 1'b0, rd, er);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h1234_5678;
        bus.req_be    = BE_WORD;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6_valid", {31'b0, bus.rsp_valid}, 32'd0);
            chk("t6_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_nores", {31'b0, bus.rsp_valid}, 32'd0);
        end
        run(1'b0, 32'h20, 32'h0, BE_WORD, 0, 1'b0, rd, er);
        chk("t6_load", rd, 32'h0BAD_F00D);

        // misaligned store
        run(1'b1, 32'h13, 32'hCAFE_F00D, BE_WORD, 0, 1'b0, rd, er);
        run(1'b0, 32'h10, 32'h0, BE_WORD, 0, 1'b0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("align_word", rd, 32'hDEAD_BEAA);
`else
        chk("align_word", rd, 32'hCAFE_F00D);
`endif

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC
                    : 32'h400 + ($urandom & 32'hFFFF);
            end else begin
                a = 32'($urandom_range(0, 15)) << 2;
                if ($urandom_range(0, 3) == 0)
                    a = a | 32'($urandom_range(1, 3));
            end
            run(1'($urandom_range(0, 1)), a, $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
